// File: rtl/exception_sequencer.sv
// rtl/exception_sequencer.sv - exception flush/vector/return sequencer with double-fault halt
// Optional EXC_STATS_EN adds exc_count_out and double_fault_out.
module exception_sequencer #(
  parameter logic [31:0] VECTOR_BASE   = 32'd16,
  parameter logic [31:0] VECTOR_STRIDE = 32'd8,
  parameter int          FLUSH_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exception_in,
  input  logic        exception_ID_in,
  input  logic        exception_EXE_in,
  input  logic        exception_MEM_in,
  input  logic [2:0]  cause_in,
  input  logic [31:0] epc_in,
  input  logic        rti_in,
  output logic        pc_load_out,
  output logic [31:0] pc_value_out,
  output logic        stall_fetch_out,
  output logic        flush_IF_ID_out,
  output logic        flush_ID_EX_out,
  output logic        flush_EX_MEM_out,
  output logic        flush_MEM_WB_out,
  output logic        in_handler_out,
  output logic        halt_out,
  output logic [2:0]  saved_cause_out,
`ifdef EXC_STATS_EN
  output logic [31:0] saved_epc_out,
  output logic [7:0]  exc_count_out,
  output logic        double_fault_out
`else
  output logic [31:0] saved_epc_out
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_VECTOR, S_HANDLER, S_RETURN, S_HALT
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [2:0]  r_saved_cause;
  logic [31:0] r_saved_epc;
`ifdef EXC_STATS_EN
  logic [7:0]  r_exc_count;
  logic        r_double_fault;
`endif

  logic [31:0] w_vector;
  logic        w_pc_load;
  logic [31:0] w_pc_value;
  logic        w_stall;
  logic [3:0]  w_flush;
  logic        w_in_handler;
  logic        w_halt;

  assign w_vector = VECTOR_BASE + ({29'd0, r_saved_cause} * VECTOR_STRIDE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_saved_cause <= 3'd0;
      r_saved_epc   <= 32'd0;
`ifdef EXC_STATS_EN
      r_exc_count    <= 8'd0;
      r_double_fault <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (exception_in) begin
            r_saved_cause <= cause_in;
            r_saved_epc   <= epc_in;
            r_cnt         <= FLUSH_LOAD;
            r_state       <= S_FLUSH;
`ifdef EXC_STATS_EN
            if (r_exc_count != 8'hFF) r_exc_count <= r_exc_count + 8'd1;
`endif
          end
        end
        S_FLUSH: begin
          if (r_cnt == 4'd0) r_state <= S_VECTOR;
          else r_cnt <= r_cnt - 4'd1;
        end
        S_VECTOR: r_state <= S_HANDLER;
        S_HANDLER: begin
          // A fault inside the handler takes priority over returning.
          if (exception_in) begin
            r_state <= S_HALT;
`ifdef EXC_STATS_EN
            r_double_fault <= 1'b1;
`endif
          end else if (rti_in) begin
            r_state <= S_RETURN;
          end
        end
        S_RETURN: r_state <= S_IDLE;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Flush set order is {IF_ID, ID_EX, EX_MEM, MEM_WB}; outputs are forced low under reset.
  always_comb begin
    w_pc_load    = 1'b0;
    w_pc_value   = 32'd0;
    w_stall      = 1'b0;
    w_flush      = 4'b0000;
    w_in_handler = 1'b0;
    w_halt       = 1'b0;
    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          if (exception_in) begin
            if (exception_MEM_in)      w_flush = 4'b1111;
            else if (exception_EXE_in) w_flush = 4'b1110;
            else                       w_flush = 4'b1100;
          end
        end
        S_FLUSH: begin
          w_stall = 1'b1;
          w_flush = 4'b1111;
        end
        S_VECTOR: begin
          w_pc_load  = 1'b1;
          w_pc_value = w_vector;
          w_flush    = 4'b1000;
        end
        S_HANDLER: begin
          w_in_handler = 1'b1;
          if (exception_in) w_flush = 4'b1111;
        end
        S_RETURN: begin
          w_pc_load    = 1'b1;
          w_pc_value   = r_saved_epc;
          w_flush      = 4'b1100;
          w_in_handler = 1'b1;
        end
        S_HALT: begin
          w_halt  = 1'b1;
          w_stall = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_load_out      = w_pc_load;
  assign pc_value_out     = w_pc_value;
  assign stall_fetch_out  = w_stall;
  assign flush_IF_ID_out  = w_flush[3];
  assign flush_ID_EX_out  = w_flush[2];
  assign flush_EX_MEM_out = w_flush[1];
  assign flush_MEM_WB_out = w_flush[0];
  assign in_handler_out   = w_in_handler;
  assign halt_out         = w_halt;
  assign saved_cause_out  = reset ? 3'd0 : r_saved_cause;
  assign saved_epc_out    = reset ? 32'd0 : r_saved_epc;
`ifdef EXC_STATS_EN
  assign exc_count_out    = r_exc_count;
  assign double_fault_out = r_double_fault;
`endif

endmodule

// File: tb/tb_exception_sequencer.sv
// tb/tb_exception_sequencer.sv - scoreboard bench for exception_sequencer
module tb_exception_sequencer;

  typedef struct packed {
    logic        pl;
    logic [31:0] pv;
    logic        st;
    logic [3:0]  fl;
    logic        ih;
    logic        h;
    logic [2:0]  sc;
    logic [31:0] se;
  } out_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc, ex_id, ex_exe, ex_mem, rti;
  logic [2:0]  cause;
  logic [31:0] epc;

  logic        pl, st, f0, f1, f2, f3, ih, h;
  logic [31:0] pv, se;
  logic [2:0]  sc;
  logic        wpl, wst, wf0, wf1, wf2, wf3, wih, wh;
  logic [31:0] wpv, wse;
  logic [2:0]  wsc;
`ifdef EXC_STATS_EN
  logic [7:0]  cnt_o, wcnt_o;
  logic        df_o, wdf_o;
`endif

  int   n_assert = 0;
  int   n_fail   = 0;
  out_t sb[$];
  out_t obs, expv;
  logic [2:0]  m_cause;
  logic [31:0] m_epc;
  int          m_cnt;

  always #5 clk = ~clk;

  exception_sequencer dut (
    .clk(clk), .reset(reset), .exception_in(exc), .exception_ID_in(ex_id),
    .exception_EXE_in(ex_exe), .exception_MEM_in(ex_mem), .cause_in(cause),
    .epc_in(epc), .rti_in(rti), .pc_load_out(pl), .pc_value_out(pv),
    .stall_fetch_out(st), .flush_IF_ID_out(f3), .flush_ID_EX_out(f2),
    .flush_EX_MEM_out(f1), .flush_MEM_WB_out(f0), .in_handler_out(ih),
    .halt_out(h), .saved_cause_out(sc),
`ifdef EXC_STATS_EN
    .exc_count_out(cnt_o), .double_fault_out(df_o),
`endif
    .saved_epc_out(se)
  );

  exception_sequencer #(
    .VECTOR_BASE(32'hFFFF_FFF0), .VECTOR_STRIDE(32'd8), .FLUSH_CYCLES(2)
  ) dut_wrap (
    .clk(clk), .reset(reset), .exception_in(exc), .exception_ID_in(ex_id),
    .exception_EXE_in(ex_exe), .exception_MEM_in(ex_mem), .cause_in(cause),
    .epc_in(epc), .rti_in(rti), .pc_load_out(wpl), .pc_value_out(wpv),
    .stall_fetch_out(wst), .flush_IF_ID_out(wf3), .flush_ID_EX_out(wf2),
    .flush_EX_MEM_out(wf1), .flush_MEM_WB_out(wf0), .in_handler_out(wih),
    .halt_out(wh), .saved_cause_out(wsc),
`ifdef EXC_STATS_EN
    .exc_count_out(wcnt_o), .double_fault_out(wdf_o),
`endif
    .saved_epc_out(wse)
  );

  function automatic out_t o(input logic p_l, input logic [31:0] p_v, input logic s_t,
                             input logic [3:0] f_l, input logic i_h, input logic h_t,
                             input logic [2:0] s_c, input logic [31:0] s_e);
    o = '{pl: p_l, pv: p_v, st: s_t, fl: f_l, ih: i_h, h: h_t, sc: s_c, se: s_e};
  endfunction

  function automatic out_t collect();
    collect = '{pl: pl, pv: pv, st: st, fl: {f3, f2, f1, f0}, ih: ih, h: h, sc: sc, se: se};
  endfunction

  task automatic drive(input logic e_x, input logic i_d, input logic e_e, input logic m_m,
                       input logic [2:0] c, input logic [31:0] e, input logic r,
                       input logic rs);
    exc = e_x; ex_id = i_d; ex_exe = e_e; ex_mem = m_m;
    cause = c; epc = e; rti = r; reset = rs;
  endtask

  task automatic check_pop(input string tag);
    obs  = collect();
    expv = sb.pop_front();
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic e_x, input logic i_d, input logic e_e, input logic m_m,
                     input logic [2:0] c, input logic [31:0] e, input logic r,
                     input logic rs, input out_t ex, input string tag);
    drive(e_x, i_d, e_e, m_m, c, e, r, rs);
    sb.push_back(ex);
    @(negedge clk);
    check_pop(tag);
    @(posedge clk); #1;
  endtask

  task automatic idle_cyc(input logic r, input logic [3:0] fl_unused, input out_t ex, input string tag);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, r, 1'b0, ex, tag);
  endtask

  // Exception accepted in IDLE followed by both FLUSH cycles; exceptions there are ignored.
  task automatic run_exc(input logic i_d, input logic e_e, input logic m_m, input logic [2:0] c,
                         input logic [31:0] e, input logic [3:0] fl, input string tag);
    cyc(1'b1, i_d, e_e, m_m, c, e, 1'b0, 1'b0, o(0, 0, 0, fl, 0, 0, m_cause, m_epc), {tag, "_detect"});
    m_cause = c; m_epc = e;
    if (m_cnt < 255) m_cnt++;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 32'hDEAD, 1'b1, 1'b0,
        o(0, 0, 1, 4'hF, 0, 0, m_cause, m_epc), {tag, "_flush1"});
    idle_cyc(1'b0, 4'h0, o(0, 0, 1, 4'hF, 0, 0, m_cause, m_epc), {tag, "_flush2"});
  endtask

  task automatic vec_cyc(input logic [31:0] v, input logic [31:0] vw, input string tag);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
    sb.push_back(o(1, v, 0, 4'b1000, 0, 0, m_cause, m_epc));
    @(negedge clk);
    check_pop(tag);
    n_assert++;
    assert ({wpl, wpv} === {1'b1, vw}) else begin
      n_fail++;
      $error("FAIL %s_wrap observed=%h expected=%h", tag, {wpl, wpv}, {1'b1, vw});
    end
    @(posedge clk); #1;
  endtask

  task automatic ret_seq(input string tag);
    idle_cyc(1'b1, 4'h0, o(0, 0, 0, 4'h0, 1, 0, m_cause, m_epc), {tag, "_hand_rti"});
    idle_cyc(1'b0, 4'h0, o(1, m_epc, 0, 4'b1100, 1, 0, m_cause, m_epc), {tag, "_return"});
    idle_cyc(1'b0, 4'h0, o(0, 0, 0, 4'h0, 0, 0, m_cause, m_epc), {tag, "_idle"});
  endtask

  task automatic reset_cyc(input string tag);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 32'hFFFF_FFFF, 1'b1, 1'b1, o(0, 0, 0, 4'h0, 0, 0, 0, 0), tag);
    m_cause = 3'd0; m_epc = 32'd0; m_cnt = 0;
  endtask

`ifdef EXC_STATS_EN
  task automatic chk_stats(input logic df, input string tag);
    n_assert++;
    assert ({cnt_o, df_o} === {8'(m_cnt), df}) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, {cnt_o, df_o}, {8'(m_cnt), df});
    end
  endtask
`endif

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1);
    m_cause = 3'd0; m_epc = 32'd0; m_cnt = 0;
    @(posedge clk); #1;
    reset_cyc("reset_override");
    idle_cyc(1'b0, 4'h0, o(0, 0, 0, 4'h0, 0, 0, 0, 0), "reset_idle");
`ifdef EXC_STATS_EN
    chk_stats(1'b0, "stats_reset");
`endif

    run_exc(1'b0, 1'b0, 1'b1, 3'd1, 32'h40, 4'b1111, "mem");
    vec_cyc(32'd24, 32'hFFFF_FFF8, "mem_vector");
    idle_cyc(1'b0, 4'h0, o(0, 0, 0, 4'h0, 1, 0, 3'd1, 32'h40), "mem_handler");
    ret_seq("mem");
    idle_cyc(1'b1, 4'h0, o(0, 0, 0, 4'h0, 0, 0, 3'd1, 32'h40), "idle_rti_ignored");
    idle_cyc(1'b0, 4'h0, o(0, 0, 0, 4'h0, 0, 0, 3'd1, 32'h40), "idle_stays");

    run_exc(1'b1, 1'b0, 1'b0, 3'd3, 32'h80, 4'b1100, "id");
    vec_cyc(32'd40, 32'h0000_0008, "id_vector");
    ret_seq("id");

    run_exc(1'b1, 1'b1, 1'b0, 3'd1, 32'h40, 4'b1110, "exe_id");
    vec_cyc(32'd24, 32'hFFFF_FFF8, "exe_vector");
    idle_cyc(1'b0, 4'h0, o(0, 0, 0, 4'h0, 1, 0, 3'd1, 32'h40), "exe_handler");

    cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 32'h999, 1'b0, 1'b0,
        o(0, 0, 0, 4'hF, 1, 0, 3'd1, 32'h40), "double_fault");
    for (int i = 0; i < 20; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)), 1'b0,
          o(0, 0, 1, 4'h0, 0, 1, 3'd1, 32'h40), "halt_hold");
`ifdef EXC_STATS_EN
    chk_stats(1'b1, "stats_halt");
`endif
    reset_cyc("reset_from_halt");
`ifdef EXC_STATS_EN
    chk_stats(1'b0, "stats_cleared");
`endif

    run_exc(1'b0, 1'b0, 1'b1, 3'd2, 32'h200, 4'b1111, "both");
    vec_cyc(32'd32, 32'h0000_0000, "both_vector");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 32'h0, 1'b1, 1'b0,
        o(0, 0, 0, 4'hF, 1, 0, 3'd2, 32'h200), "exc_and_rti");
    idle_cyc(1'b0, 4'h0, o(0, 0, 1, 4'h0, 0, 1, 3'd2, 32'h200), "exc_and_rti_halt");
    reset_cyc("reset_from_halt2");

    cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 32'h300, 1'b0, 1'b0,
        o(0, 0, 0, 4'hF, 0, 0, 3'd0, 32'd0), "midflush_detect");
    m_cause = 3'd5; m_epc = 32'h300; m_cnt++;
    idle_cyc(1'b0, 4'h0, o(0, 0, 1, 4'hF, 0, 0, 3'd5, 32'h300), "midflush_flush1");
    reset_cyc("reset_midflush");
    idle_cyc(1'b0, 4'h0, o(0, 0, 0, 4'h0, 0, 0, 3'd0, 32'd0), "after_midflush_reset");

    run_exc(1'b0, 1'b0, 1'b1, 3'd6, 32'h100, 4'b1111, "wrap");
    vec_cyc(32'd64, 32'h0000_0020, "wrap_vector");
    ret_seq("wrap");

    for (int i = 0; i < 300; i++) begin
      run_exc(1'b0, 1'b1, 1'b0, 3'd2, 32'h1000 + 32'(i), 4'b1110, "loop");
      vec_cyc(32'd32, 32'h0000_0000, "loop_vector");
      ret_seq("loop");
    end
`ifdef EXC_STATS_EN
    chk_stats(1'b0, "stats_saturated");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
